moore_10101_detector: RTL and testbench



---
 rtl/moore_10101_detector.sv | 56 +++++
 tb/tb_moore_10101_detector.sv | 135 +++++++++++++
 2 files changed

// File: rtl/moore_10101_detector.sv
// Moore detector for the serial pattern 1-0-1-0-1; `out` is the one-hot state register.
// Define MOORE_10101_OVERLAP_EN for overlapping detection (DETECT + x=0 -> "1010").
module moore_10101_detector (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    output logic [4:0] out,
    output logic       z
);

    typedef enum logic [4:0] {
        S0 = 5'b00000,
        S1 = 5'b00001,
        S2 = 5'b00010,
        S3 = 5'b00100,
        S4 = 5'b01000,
        S5 = 5'b10000
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   z_q;

    always_comb begin
        state_d = S0;
        case (state_q)
            S0: state_d = x ? S1 : S0;
            S1: state_d = x ? S1 : S2;
            S2: state_d = x ? S3 : S0;
            S3: state_d = x ? S1 : S4;
            S4: state_d = x ? S5 : S0;
`ifdef MOORE_10101_OVERLAP_EN
            S5: state_d = x ? S1 : S4;
`else
            S5: state_d = x ? S1 : S0;
`endif
            // Any multi-hot value falls back to idle.
            default: state_d = S0;
        endcase
    end

    // z is registered alongside the state so it is a pure function of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= (state_d == S5);
        end
    end

    assign out = state_q;
    assign z   = z_q;

endmodule

// File: tb/tb_moore_10101_detector.sv
// Randomized + directed bench for moore_10101_detector against a suffix-matching model.
// Honors MOORE_10101_OVERLAP_EN the same way the design does.
module tb_moore_10101_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       x;
    logic [4:0] out;
    logic       z;

    int total = 0;
    int bad   = 0;

    // Model: recent input bits since reset (bit 0 newest) and how many are valid.
    logic [4:0] hist_bits = 5'b0;
    int         hist_n    = 0;

    moore_10101_detector dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .out   (out),
        .z     (z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Length of the longest tail of the history that is a prefix of 10101.
    function automatic int match_len(input logic [4:0] h, input int n);
        logic [4:0] pat;
        logic [4:0] mask;
        int lim;
        lim = (n > 5) ? 5 : n;
        for (int k = lim; k >= 1; k--) begin
            pat  = 5'b10101 >> (5 - k);
            mask = 5'b11111 >> (5 - k);
            if ((h & mask) == pat) return k;
        end
        return 0;
    endfunction

    // Apply one edge with given inputs, update the model, compare outputs.
    task automatic step(input logic r, input logic b, input string tag);
        int k;
        logic [4:0] exp_out;
        logic       exp_z;
        @(negedge clk);
        reset = r;
        x     = b;
        @(posedge clk);
        #1;
        if (r) begin
            hist_bits = 5'b0;
            hist_n    = 0;
            k         = 0;
        end else begin
            hist_bits = {hist_bits[3:0], b};
            hist_n    = (hist_n < 5) ? hist_n + 1 : 5;
            k         = match_len(hist_bits, hist_n);
`ifndef MOORE_10101_OVERLAP_EN
            if (k == 5) begin
                hist_bits = 5'b0;
                hist_n    = 0;
            end
`endif
        end
        exp_out = (k == 0) ? 5'b00000 : (5'b00001 << (k - 1));
        exp_z   = (k == 5);
        $display("step %s reset=%b x=%b out=%b z=%b", tag, r, b, out, z);
        chk({tag, ".out"}, out, exp_out);
        chk({tag, ".z"}, {4'b0, z}, {4'b0, exp_z});
    endtask

    task automatic send(input logic [15:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) step(1'b0, bits[i], tag);
    endtask

    initial begin
        reset = 1'b1;
        x     = 1'b0;
        #20;
        #1;
        chk("reset.out", out, 5'b00000);
        chk("reset.z", {4'b0, z}, 5'b00000);
        hist_bits = 5'b0;
        hist_n    = 0;

        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "idle0");

        step(1'b1, 1'b0, "rst");
        send(16'b10101, 5, "single");
        step(1'b0, 1'b0, "after_match");

        step(1'b1, 1'b0, "rst");
        send(16'b1010101, 7, "overlap");

        step(1'b1, 1'b0, "rst");
        send(16'b101101101110, 12, "prefix");
        chk("prefix.final", out, 5'b00010);

        step(1'b1, 1'b0, "rst");
        send(16'b100, 3, "dead3");
        step(1'b1, 1'b0, "rst");
        send(16'b10100, 5, "dead5");

        step(1'b1, 1'b0, "rst");
        send(16'b1010, 4, "to_s4");
        chk("to_s4.state", out, 5'b01000);
        step(1'b1, 1'b1, "midrst");
        chk("midrst.out", out, 5'b00000);
        step(1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 600; i++) begin
            logic r;
            logic b;
            r = ($urandom_range(0, 49) == 0);
            // Bias toward alternating bits so matches occur often.
            if ($urandom_range(0, 3) != 0) b = ~x;
            else b = $urandom_range(0, 1);
            step(r, b, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
